// File: rtl/mem_io_bridge.sv
// Memory-mapped bridge between the processor bus and on-chip RAM, LEDs, HEX displays,
// switches and a prescaled countdown timer. Read data appears one cycle after ADDR.
module mem_io_bridge #(
  parameter int RAM_AW    = 8,
  parameter int PRESCALE  = 50000,
  parameter     INIT_FILE = ""
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] DIN,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic        TIMER_IRQ
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic {T_IDLE, T_RUN} tstate_t;

  logic [3:0]  region;
  logic        ram_we, led_we, hex_we, tmr_we, load_wr, clr_wr;

  assign region  = ADDR[15:12];
  assign ram_we  = W && (region == 4'h0);
  assign led_we  = W && (region == 4'h1);
  assign hex_we  = W && (region == 4'h2);
  assign tmr_we  = W && (region == 4'h4);
  assign load_wr = tmr_we && (ADDR[1:0] == 2'd0);
  assign clr_wr  = tmr_we && (ADDR[1:0] == 2'd1) && DOUT[0];

  // RAM: plain array with registered read so it maps onto block RAM (read-before-write)
  logic [15:0] mem [0:(1<<RAM_AW)-1];
  logic [15:0] ram_q_reg;

  always_ff @(posedge Clock) begin
    if (ram_we)
      mem[ADDR[RAM_AW-1:0]] <= DOUT;
    ram_q_reg <= mem[ADDR[RAM_AW-1:0]];
  end

  logic [9:0] ledr_reg;

  always_ff @(posedge Clock) begin
    if (Reset)
      ledr_reg <= '0;
    else if (led_we)
      ledr_reg <= DOUT[9:0];
  end

  logic [6:0] hex_reg [0:5];

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_hex
      always_ff @(posedge Clock) begin
        if (Reset)
          hex_reg[gi] <= 7'h7F;
        else if (hex_we && (ADDR[2:0] == 3'(gi)))
          hex_reg[gi] <= DOUT[6:0];
      end
    end
  endgenerate

  logic [9:0] sw_meta_reg, sw_sync_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= SW;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  // Countdown timer
  tstate_t       state_reg, state_next;
  logic [15:0]   count_reg;
  logic [PW-1:0] presc_reg;
  logic          expired_reg;
  logic          running, tick, expire;

  assign tick   = (state_reg == T_RUN) && (presc_reg == PRESC_MAX);
  assign expire = tick && (count_reg == 16'd1) && !load_wr;

  always_ff @(posedge Clock) begin
    if (Reset)
      state_reg <= T_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (load_wr)
      state_next = (DOUT != 16'd0) ? T_RUN : T_IDLE;
    else if (expire)
      state_next = T_IDLE;
  end

  always_comb begin
    running = (state_reg == T_RUN);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_reg   <= '0;
      presc_reg   <= '0;
      expired_reg <= 1'b0;
    end else if (load_wr) begin
      count_reg   <= DOUT;
      presc_reg   <= '0;
      expired_reg <= (DOUT == 16'd0);
    end else begin
      if (state_reg == T_RUN) begin
        if (tick) begin
          presc_reg <= '0;
          count_reg <= count_reg - 16'd1;
        end else begin
          presc_reg <= presc_reg + PW'(1);
        end
      end
      // An expiry on the same edge as a clear-write leaves the flag set
      if (expire)
        expired_reg <= 1'b1;
      else if (clr_wr)
        expired_reg <= 1'b0;
    end
  end

  // Peripheral read data is captured on the same edge as the RAM read
  logic [15:0] periph_rd;
  logic [15:0] periph_q_reg;
  logic        sel_ram_reg;

  always_comb begin
    periph_rd = '0;
    case (region)
      4'h1: periph_rd = {6'b0, ledr_reg};
      4'h2: if (ADDR[2:0] < 3'd6) periph_rd = {9'b0, hex_reg[ADDR[2:0]]};
      4'h3: periph_rd = {6'b0, sw_sync_reg};
      4'h4: begin
        case (ADDR[1:0])
          2'd1:    periph_rd = {14'b0, running, expired_reg};
          2'd2:    periph_rd = count_reg;
          default: periph_rd = '0;
        endcase
      end
      default: periph_rd = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      periph_q_reg <= '0;
      sel_ram_reg  <= 1'b0;
    end else begin
      periph_q_reg <= periph_rd;
      sel_ram_reg  <= (region == 4'h0);
    end
  end

  assign DIN       = sel_ram_reg ? ram_q_reg : periph_q_reg;
  assign LEDR      = ledr_reg;
  assign HEX0      = hex_reg[0];
  assign HEX1      = hex_reg[1];
  assign HEX2      = hex_reg[2];
  assign HEX3      = hex_reg[3];
  assign HEX4      = hex_reg[4];
  assign HEX5      = hex_reg[5];
  assign TIMER_IRQ = expired_reg;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: directed scenarios plus random bus traffic
// compared against an edge-indexed behavioural model of the memory map.
module tb_mem_io_bridge;

  localparam int P = 4;
  localparam int HMAX = 4096;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] ADDR  = '0;
  logic [15:0] DOUT  = '0;
  logic        W     = 1'b0;
  logic [9:0]  SW    = '0;
  logic [15:0] DIN;
  logic [9:0]  LEDR;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic        TIMER_IRQ;

  mem_io_bridge #(.RAM_AW(8), .PRESCALE(P), .INIT_FILE("")) dut (
    .Clock(Clock), .Reset(Reset), .ADDR(ADDR), .DOUT(DOUT), .W(W), .DIN(DIN),
    .SW(SW), .LEDR(LEDR), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5), .TIMER_IRQ(TIMER_IRQ)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model, indexed by clock edge number
  logic [15:0] m_mem  [256];
  bit          m_memv [256];
  logic [9:0]  m_ledr;
  logic [6:0]  m_hex  [6];
  logic [9:0]  sw_hist [HMAX];
  int          n = 0;
  int          last_rst = 0;
  bit          t_loaded;
  int          t_l, t_val;
  bit          m_exp;

  function automatic int m_count();
    int c;
    if (!t_loaded) return 0;
    c = t_val - (n - 1 - t_l) / P;
    return (c < 0) ? 0 : c;
  endfunction

  function automatic bit m_running();
    return t_loaded && ((n - 1) < (t_l + t_val * P));
  endfunction

  task automatic model_edge(input logic rst, input logic [15:0] a, input logic [15:0] d,
                            input logic w, input logic [9:0] sw,
                            output logic [15:0] exp_din, output bit known);
    logic [3:0] rg;
    bit is_load, expiry;
    sw_hist[n % HMAX] = sw;
    known = 1'b1;
    exp_din = '0;
    if (rst) begin
      m_ledr = '0;
      for (int i = 0; i < 6; i++) m_hex[i] = 7'h7F;
      t_loaded = 0; m_exp = 0; last_rst = n;
      n++;
      return;
    end
    rg = a[15:12];
    case (rg)
      4'h0: begin exp_din = m_mem[a[7:0]]; known = m_memv[a[7:0]]; end
      4'h1: exp_din = {6'b0, m_ledr};
      4'h2: exp_din = (a[2:0] < 6) ? {9'b0, m_hex[a[2:0]]} : 16'h0;
      4'h3: exp_din = (n - 2 > last_rst) ? {6'b0, sw_hist[(n - 2) % HMAX]} : 16'h0;
      4'h4: begin
        if (a[1:0] == 2'd1) exp_din = {14'b0, m_running(), m_exp};
        else if (a[1:0] == 2'd2) exp_din = 16'(m_count());
      end
      default: exp_din = '0;
    endcase
    is_load = w && rg == 4'h4 && a[1:0] == 2'd0;
    expiry  = t_loaded && t_val > 0 && n == t_l + t_val * P && !is_load;
    if (w) begin
      case (rg)
        4'h0: begin m_mem[a[7:0]] = d; m_memv[a[7:0]] = 1; end
        4'h1: m_ledr = d[9:0];
        4'h2: if (a[2:0] < 6) m_hex[a[2:0]] = d[6:0];
        4'h4: if (is_load) begin t_loaded = 1; t_l = n; t_val = int'(d); m_exp = (d == 0); end
        default: ;
      endcase
    end
    if (expiry) m_exp = 1;
    else if (!is_load && w && rg == 4'h4 && a[1:0] == 2'd1 && d[0]) m_exp = 0;
    n++;
  endtask

  int txn = 0;

  task automatic step(input logic rst, input logic [15:0] a, input logic [15:0] d,
                      input logic w, input logic [9:0] sw);
    logic [15:0] exp_din;
    bit known;
    logic [41:0] exp_hex;
    @(negedge Clock);
    Reset = rst; ADDR = a; DOUT = d; W = w; SW = sw;
    model_edge(rst, a, d, w, sw, exp_din, known);
    @(posedge Clock);
    #1;
    if (known) check("din", 64'(DIN), 64'(exp_din));
    check("ledr", 64'(LEDR), 64'(m_ledr));
    exp_hex = {m_hex[5], m_hex[4], m_hex[3], m_hex[2], m_hex[1], m_hex[0]};
    check("hex", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'(exp_hex));
    check("irq", 64'(TIMER_IRQ), 64'(m_exp));
    $display("txn %0d rst=%0b addr=%h w=%0b dout=%h din=%h ledr=%h irq=%0b",
             txn, rst, a, w, d, DIN, LEDR, TIMER_IRQ);
    txn++;
  endtask

  initial begin
    logic [3:0] rg;
    logic [15:0] a, d;
    logic w;
    logic [9:0] sw_val;
    int r;

    for (int i = 0; i < 256; i++) m_memv[i] = 0;
    for (int i = 0; i < 6; i++) m_hex[i] = 7'h7F;
    m_ledr = '0; t_loaded = 0; m_exp = 0;

    step(1, 16'h0000, 16'h0000, 0, 10'h000);
    step(1, 16'h0000, 16'h0000, 0, 10'h000);
    check("rst_din", 64'(DIN), 64'h0);
    check("rst_hex0", 64'(HEX0), 64'h7F);

    // RAM write, read, alias, read-before-write
    step(0, 16'h0005, 16'hBEEF, 1, 10'h000);
    step(0, 16'h0005, 16'h0000, 0, 10'h000);
    check("ram_rd", 64'(DIN), 64'hBEEF);
    step(0, 16'h0105, 16'h0000, 0, 10'h000);
    check("ram_alias", 64'(DIN), 64'hBEEF);
    step(0, 16'h0005, 16'h1234, 1, 10'h000);
    check("ram_rbw", 64'(DIN), 64'hBEEF);
    step(0, 16'h0005, 16'h0000, 0, 10'h000);
    check("ram_new", 64'(DIN), 64'h1234);

    // LEDR and HEX
    step(0, 16'h1000, 16'h03FF, 1, 10'h000);
    check("ledr_wr", 64'(LEDR), 64'h3FF);
    step(0, 16'h1000, 16'h0000, 0, 10'h000);
    check("ledr_rd", 64'(DIN), 64'h03FF);
    step(0, 16'h2006, 16'h0011, 1, 10'h000);
    check("hex_ign", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), {22'b0, {6{7'h7F}}});
    step(0, 16'h2002, 16'h0040, 1, 10'h000);
    check("hex2_wr", 64'(HEX2), 64'h40);

    // Switch synchronizer latency
    step(0, 16'h3000, 16'h0000, 0, 10'h155);
    step(0, 16'h3000, 16'h0000, 0, 10'h155);
    step(0, 16'h3000, 16'h0000, 0, 10'h155);
    check("sw_rd", 64'(DIN), 64'h0155);
    step(0, 16'h3000, 16'h0000, 1, 10'h155);
    step(0, 16'h3000, 16'h0000, 0, 10'h155);
    check("sw_ro", 64'(DIN), 64'h0155);

    // Timer: LOAD 3 with PRESCALE 4 expires 12 edges later
    step(0, 16'h4000, 16'h0003, 1, 10'h155);
    for (int i = 0; i < 11; i++) step(0, 16'h7000, 16'h0000, 0, 10'h155);
    check("irq_early", 64'(TIMER_IRQ), 64'h0);
    step(0, 16'h7000, 16'h0000, 0, 10'h155);
    check("irq_rise", 64'(TIMER_IRQ), 64'h1);
    step(0, 16'h4001, 16'h0000, 0, 10'h155);
    check("status", 64'(DIN), 64'h0001);
    step(0, 16'h4001, 16'h0001, 1, 10'h155);
    check("irq_clr", 64'(TIMER_IRQ), 64'h0);
    step(0, 16'h4000, 16'h0000, 1, 10'h155);
    check("irq_load0", 64'(TIMER_IRQ), 64'h1);

    // Reset mid-countdown
    step(0, 16'h4000, 16'h0005, 1, 10'h155);
    for (int i = 0; i < 3; i++) step(0, 16'h7000, 16'h0000, 0, 10'h155);
    step(1, 16'h7000, 16'h0000, 0, 10'h155);
    check("rst_irq", 64'(TIMER_IRQ), 64'h0);
    check("rst_ledr", 64'(LEDR), 64'h0);
    check("rst_hex2", 64'(HEX2), 64'h7F);
    step(0, 16'h4002, 16'h0000, 0, 10'h155);
    check("rst_count", 64'(DIN), 64'h0);
    step(0, 16'h7000, 16'h0000, 0, 10'h155);
    check("unmapped", 64'(DIN), 64'h0);

    // Random traffic
    sw_val = 10'h2A5;
    for (int t = 0; t < 600; t++) begin
      r = int'($urandom_range(0, 99));
      case ($urandom_range(0, 9))
        0, 1, 2: rg = 4'h0;
        3:       rg = 4'h1;
        4:       rg = 4'h2;
        5:       rg = 4'h3;
        6, 7:    rg = 4'h4;
        8:       rg = 4'(5 + $urandom_range(0, 10));
        default: rg = 4'h4;
      endcase
      a = {rg, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
      d = 16'($urandom);
      w = 1'($urandom_range(0, 1));
      if (rg == 4'h4 && a[1:0] == 2'd0 && r < 90) d = 16'($urandom_range(0, 5));
      if (r % 10 == 3) sw_val = 10'($urandom);
      step(r == 0, a, d, w, sw_val);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
